// File: rtl/mac_accumulator.sv
// Purpose: folds a registered 32-bit product into an ACC_W accumulator (clear/load/add/sub).
// Latency: accept edge -> EXEC, next edge -> DONE with result held; 1 op per 2 cycles streaming.
// Backpressure: result held in DONE until i_out_ready; o_in_ready follows i_out_ready in DONE.
module mac_accumulator #(
    parameter int ACC_W = 40,
    parameter int SAT   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_prod,
    input  logic [1:0]       i_op,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_acc_out,
    output logic             o_ovf,
    output logic [7:0]       o_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_prod;
    logic [1:0]         r_op;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [7:0]         r_cnt;

    logic               w_accept;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W:0]     w_diff;
    logic [7:0]         w_cnt_inc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_ovf_nxt;
    logic [7:0]         w_cnt_nxt;

    // Next-state and handshake decode; in_ready is forced low while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_state_nxt = EXEC;
            end
            EXEC: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                o_in_ready = i_out_ready;
                if (i_out_ready) w_state_nxt = i_in_valid ? EXEC : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (i_rst) o_in_ready = 1'b0;
    end

    assign w_accept   = i_in_valid & o_in_ready;
    assign w_prod_ext = {{(ACC_W-32){1'b0}}, r_prod};
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
    // Top bit of the widened difference is the borrow, i.e. prod > acc.
    assign w_diff     = {1'b0, r_acc} - {1'b0, w_prod_ext};
    assign w_cnt_inc  = (r_cnt == 8'hFF) ? 8'hFF : (r_cnt + 8'd1);

    // Accumulator update for the captured opcode; ovf is sticky across ADD/SUB.
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        w_cnt_nxt = r_cnt;
        case (r_op)
            OP_CLEAR: begin
                w_acc_nxt = '0;
                w_ovf_nxt = 1'b0;
                w_cnt_nxt = 8'd0;
            end
            OP_LOAD: begin
                w_acc_nxt = w_prod_ext;
                w_ovf_nxt = 1'b0;
                w_cnt_nxt = 8'd0;
            end
            OP_ADD: begin
                w_cnt_nxt = w_cnt_inc;
                w_acc_nxt = w_sum[ACC_W-1:0];
                if (w_sum[ACC_W]) begin
                    w_ovf_nxt = 1'b1;
                    if (SAT != 0) w_acc_nxt = '1;
                end
            end
            OP_SUB: begin
                w_cnt_nxt = w_cnt_inc;
                w_acc_nxt = w_diff[ACC_W-1:0];
                if (w_diff[ACC_W]) begin
                    w_ovf_nxt = 1'b1;
                    if (SAT != 0) w_acc_nxt = '0;
                end
            end
            default: begin
                w_acc_nxt = r_acc;
            end
        endcase
    end

    // State, operand capture on accept, and accumulator commit in EXEC.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_prod  <= '0;
            r_op    <= OP_CLEAR;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_prod <= i_prod;
                r_op   <= i_op;
            end
            if (r_state == EXEC) begin
                r_acc <= w_acc_nxt;
                r_ovf <= w_ovf_nxt;
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    assign o_out_valid = (r_state == DONE);
    assign o_acc_out   = r_acc;
    assign o_ovf       = r_ovf;
    assign o_cnt       = r_cnt;

endmodule

// File: tb/tb_mac_accumulator.sv
// Purpose: directed checks of mac_accumulator, saturating and wrapping builds side by side.
// Latency: inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Backpressure: exercised by holding out_ready low in DONE with a pending request.
module tb_mac_accumulator;

    localparam int ACC_W = 40;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [31:0]      prod;
    logic [1:0]       op;
    logic             out_ready;

    logic             s_in_ready, s_out_valid, s_ovf;
    logic [ACC_W-1:0] s_acc;
    logic [7:0]       s_cnt;
    logic             w_in_ready, w_out_valid, w_ovf;
    logic [ACC_W-1:0] w_acc;
    logic [7:0]       w_cnt;

    int checks = 0;
    int errors = 0;

    mac_accumulator #(.ACC_W(ACC_W), .SAT(1)) u_dut_sat (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (s_in_ready),
        .i_prod      (prod),
        .i_op        (op),
        .o_out_valid (s_out_valid),
        .i_out_ready (out_ready),
        .o_acc_out   (s_acc),
        .o_ovf       (s_ovf),
        .o_cnt       (s_cnt)
    );

    mac_accumulator #(.ACC_W(ACC_W), .SAT(0)) u_dut_wrap (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (w_in_ready),
        .i_prod      (prod),
        .i_op        (op),
        .o_out_valid (w_out_valid),
        .i_out_ready (out_ready),
        .o_acc_out   (w_acc),
        .o_ovf       (w_ovf),
        .o_cnt       (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        prod      = 32'd0;
        op        = 2'b00;
        out_ready = 1'b0;

        // Reset
        step();
        check_val("rst_in_ready",  64'(s_in_ready),  64'd0);
        check_val("rst_out_valid", 64'(s_out_valid), 64'd0);
        check_val("rst_acc",       64'(s_acc),       64'd0);
        check_val("rst_ovf",       64'(s_ovf),       64'd0);
        check_val("rst_cnt",       64'(s_cnt),       64'd0);
        rst = 1'b0;
        #1;
        check_val("post_rst_in_ready", 64'(s_in_ready), 64'd1);
        step();

        // LOAD 6 with consumer stalled, then release
        in_valid = 1'b1; op = 2'b01; prod = 32'h6;
        step();
        in_valid = 1'b0;
        check_val("load_exec_valid", 64'(s_out_valid), 64'd0);
        check_val("load_exec_rdy",   64'(s_in_ready),  64'd0);
        step();
        check_val("load_out_valid", 64'(s_out_valid), 64'd1);
        check_val("load_acc",       64'(s_acc),       64'h6);
        check_val("load_cnt",       64'(s_cnt),       64'd0);
        check_val("load_ovf",       64'(s_ovf),       64'd0);
        check_val("load_done_rdy",  64'(s_in_ready),  64'd0);
        out_ready = 1'b1;
        #1;
        check_val("load_done_rdy_hi", 64'(s_in_ready), 64'd1);
        step();
        check_val("load_idle_valid", 64'(s_out_valid), 64'd0);
        check_val("load_idle_rdy",   64'(s_in_ready),  64'd1);

        // LOAD 0xFFFE0001 then 255 streaming ADDs, then one more ADD, then CLEAR
        in_valid = 1'b1; op = 2'b01; prod = 32'hFFFE_0001;
        step();
        op = 2'b10;
        for (int k = 0; k < 255; k++) begin
            step();
            if (k == 0) begin
                check_val("stream_load_valid", 64'(s_out_valid), 64'd1);
                check_val("stream_load_acc",   64'(s_acc),       64'hFFFE_0001);
            end
            if (k == 1) begin
                check_val("stream_add1_acc", 64'(s_acc), 64'h1_FFFC_0002);
                check_val("stream_add1_cnt", 64'(s_cnt), 64'd1);
            end
            step();
            if (k == 0) check_val("stream_exec_valid", 64'(s_out_valid), 64'd0);
        end
        step();
        check_val("sum256_acc",      64'(s_acc),  64'hFF_FE00_0100);
        check_val("sum256_cnt",      64'(s_cnt),  64'd255);
        check_val("sum256_ovf",      64'(s_ovf),  64'd0);
        check_val("sum256_wrap_ovf", 64'(w_ovf),  64'd0);
        step();
        op = 2'b00;
        step();
        check_val("sat_add_acc",  64'(s_acc),  64'hFF_FFFF_FFFF);
        check_val("sat_add_ovf",  64'(s_ovf),  64'd1);
        check_val("sat_add_cnt",  64'(s_cnt),  64'd255);
        check_val("wrap_add_acc", 64'(w_acc),  64'h00_FDFE_0101);
        check_val("wrap_add_ovf", 64'(w_ovf),  64'd1);
        step();
        in_valid = 1'b0;
        step();
        check_val("clear_valid", 64'(s_out_valid), 64'd1);
        check_val("clear_acc",   64'(s_acc),       64'd0);
        check_val("clear_ovf",   64'(s_ovf),       64'd0);
        check_val("clear_cnt",   64'(s_cnt),       64'd0);
        step();

        // LOAD 0x10 then SUB 0x20 underflow
        in_valid = 1'b1; op = 2'b01; prod = 32'h10;
        step();
        op = 2'b11; prod = 32'h20;
        step();
        check_val("sub_pre_acc", 64'(s_acc), 64'h10);
        step();
        in_valid = 1'b0;
        step();
        check_val("sub_sat_acc",  64'(s_acc), 64'd0);
        check_val("sub_sat_ovf",  64'(s_ovf), 64'd1);
        check_val("sub_wrap_acc", 64'(w_acc), 64'hFF_FFFF_FFF0);
        check_val("sub_wrap_ovf", 64'(w_ovf), 64'd1);
        check_val("sub_cnt",      64'(s_cnt), 64'd1);
        step();

        // Backpressure: LOAD 0x100, stall 5 cycles with a pending ADD
        out_ready = 1'b0;
        in_valid = 1'b1; op = 2'b01; prod = 32'h100;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1; op = 2'b10; prod = 32'h11;
        for (int k = 0; k < 5; k++) begin
            check_val("bp_valid", 64'(s_out_valid), 64'd1);
            check_val("bp_acc",   64'(s_acc),       64'h100);
            check_val("bp_ovf",   64'(s_ovf),       64'd0);
            check_val("bp_cnt",   64'(s_cnt),       64'd0);
            check_val("bp_rdy",   64'(s_in_ready),  64'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_release_rdy", 64'(s_in_ready), 64'd1);
        step();
        check_val("bp_exec_valid", 64'(s_out_valid), 64'd0);
        in_valid = 1'b0;
        prod = 32'hFFFF;
        step();
        check_val("bp_add_valid", 64'(s_out_valid), 64'd1);
        check_val("bp_add_acc",   64'(s_acc),       64'h111);
        check_val("bp_add_cnt",   64'(s_cnt),       64'd1);
        step();

        // Reset during EXEC of an ADD drops the operation
        in_valid = 1'b1; op = 2'b10; prod = 32'h5;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check_val("rst_exec_valid", 64'(s_out_valid), 64'd0);
        check_val("rst_exec_acc",   64'(s_acc),       64'd0);
        check_val("rst_exec_cnt",   64'(s_cnt),       64'd0);
        rst = 1'b0;
        #1;
        check_val("rst_exec_rdy", 64'(s_in_ready), 64'd1);
        step();
        check_val("rst_exec_dropped", 64'(s_out_valid), 64'd0);
        check_val("rst_exec_acc2",    64'(s_acc),       64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
